// File: rtl/binary_div_pkg.sv
// Shared definitions for the signed restoring divider.
//   DEF_DW / DEF_VW : default dividend/quotient and divisor/remainder widths
//   MIN_DIVIDEND    : most negative dividend at the default width (-2^(DW-1));
//                     dividing it by -1 is the overflow case
//   state_t         : divider FSM states
package binary_div_pkg;

  localparam int DEF_DW = 7;
  localparam int DEF_VW = 4;

  localparam logic signed [DEF_DW-1:0] MIN_DIVIDEND = {1'b1, {(DEF_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/binary_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   pr      : partial remainder before the step (VW+1 bits)
//   dbit    : next dividend bit, MSB first
//   dvs     : divisor magnitude
//   pr_next : partial remainder after the step
//   qbit    : quotient bit produced by the step
module binary_div_step
  import binary_div_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW:0]   pr,
  input  logic          dbit,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   pr_next,
  output logic          qbit
);

  logic [VW+1:0] shifted;
  logic [VW:0]   diff;

  // Because pr < dvs going in, the shifted value is below 2*dvs and fits in
  // VW+1 bits whenever the subtraction is kept; the full-width compare is
  // what decides keep versus restore.
  always_comb begin
    shifted = {pr, dbit};
    diff    = shifted[VW:0] - {1'b0, dvs};
    qbit    = (shifted >= {2'b00, dvs});
    pr_next = qbit ? diff : shifted[VW:0];
  end

endmodule

// File: rtl/binary_div_7_4_bi.sv
// Sequential signed restoring divider, quotient and remainder truncated
// toward zero (matches Verilog signed / and %).
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   en             : clock enable, low freezes every register
//   in_valid/ready : operand handshake (dividend, divisor)
//   out_valid/ready: result handshake (quotient, remainder, dz, ovf)
//   state_dbg      : current FSM state for observation
//
// Handshake: a transfer happens on an enabled rising edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high only
// in DONE and the result registers hold until the next FIX. in_valid outside
// IDLE and out_ready outside DONE are ignored.
//
// Latency is fixed: acceptance edge, DW CALC edges, one FIX edge, so
// out_valid rises DW+1 enabled edges after acceptance, regardless of dz/ovf.
module binary_div_7_4_bi
  import binary_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [VW-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] quotient,
  output logic signed [VW-1:0] remainder,
  output logic                 dz,
  output logic                 ovf,
  output state_t               state_dbg
);

  localparam int            CW       = $clog2(DW);
  localparam logic [DW-1:0] MIN_DVD  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  // Holds the dividend magnitude; each step shifts one dividend bit out of
  // the top and one quotient bit into the bottom, so after DW steps it holds
  // the quotient magnitude.
  logic [DW-1:0] work;
  logic [VW:0]   pr;
  logic [VW:0]   pr_next;
  logic [VW-1:0] dvs;
  logic [VW-1:0] raw_lo;
  logic          q_neg;
  logic          r_neg;
  logic          dz_p;
  logic          ovf_p;
  logic          qbit;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;

  // Magnitudes: -(-2^(DW-1)) and -(-2^(VW-1)) are still correct when read
  // as unsigned values of the same width.
  always_comb begin
    dvd_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[VW-1]  ? (~divisor + 1'b1)  : divisor;
    q_fix   = q_neg ? (~work + 1'b1) : work;
    r_fix   = r_neg ? (~pr[VW-1:0] + 1'b1) : pr[VW-1:0];
  end

  binary_div_step #(
    .VW(VW)
  ) u_step (
    .pr     (pr),
    .dbit   (work[DW-1]),
    .dvs    (dvs),
    .pr_next(pr_next),
    .qbit   (qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Next-state logic (en is applied at the register)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      work      <= '0;
      pr        <= '0;
      dvs       <= '0;
      raw_lo    <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz_p      <= 1'b0;
      ovf_p     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= dvd_mag;
            dvs    <= dvs_mag;
            pr     <= '0;
            cnt    <= CNT_INIT;
            q_neg  <= dividend[DW-1] ^ divisor[VW-1];
            r_neg  <= dividend[DW-1];
            dz_p   <= (divisor == '0);
            ovf_p  <= (dividend == MIN_DVD) && (divisor == '1);
            raw_lo <= dividend[VW-1:0];
          end
        end
        CALC: begin
          pr   <= pr_next;
          work <= {work[DW-2:0], qbit};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          // The steps still ran for dz/ovf so latency stays fixed; their
          // result is simply replaced here.
          if (dz_p) begin
            quotient  <= '1;
            remainder <= raw_lo;
            dz        <= 1'b1;
            ovf       <= 1'b0;
          end else if (ovf_p) begin
            quotient  <= MIN_DVD;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            dz        <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
